ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- ADDR_W, 26, RAM word address width
- DATA_W, 16, RAM data width
- TMO_W, 10, read-timeout counter width; timeout fires at 2^TMO_W-1 cycles
REQ-002 The block SHALL have these ports, one per line: name  direction  width  meaning.
- clk  in  1  system clock (100 MHz domain); the only clock
- reset  in  1  asynchronous, active-low reset
- a_req  in  1  requester A (PicoBlaze port logic) request, level
- a_we  in  1  A: 1=write, 0=read
- a_addr  in  ADDR_W  A address
- a_wdata  in  DATA_W  A write data
- a_gnt  out  1  A accepted this cycle
- a_done  out  1  A transaction complete, 1-cycle pulse
- a_rdata  out  DATA_W  A read data, valid with a_done
- b_req, b_we, b_addr, b_wdata, b_gnt, b_done, b_rdata  same widths/meanings for requester B (audio stream)
- ram_addr  out  ADDR_W  to wrapper address
- ram_din  out  DATA_W  to wrapper data_in
- ram_we  out  1  to wrapper write_enable
- ram_rd_req  out  1  to wrapper read_request
- ram_rd_ack  out  1  to wrapper read_ack
- ram_dout  in  DATA_W  from wrapper data_out
- ram_rdy  in  1  wrapper calibrated/ready
- ram_rd_pres  in  1  wrapper read data present
- ram_max_addr  in  ADDR_W  highest legal address
- busy  out  1  state != IDLE
- err  out  1  1-cycle pulse: address out of range or read timeout

Function
REQ-003 FSM states SHALL be IDLE, WRITE, RD_REQ, RD_WAIT, DONE.
REQ-004 In IDLE with ram_rdy=1 and at least one req high, the arbiter SHALL accept exactly one requester, assert its gnt combinationally in that cycle, and latch that requester's we/addr/wdata plus an owner ID.
REQ-005 Arbitration SHALL be round-robin: when both requests are high, the requester not served last wins; after reset, B is treated as having priority.
REQ-006 In IDLE with ram_rdy=0, no gnt SHALL be issued.
REQ-007 Requester inputs SHALL be sampled only in the gnt cycle; a requester may change or hold req from the next cycle, and a held req counts as a new transaction.
REQ-008 If the latched address > ram_max_addr, the next state SHALL be DONE with err pulsed in that DONE cycle, rdata=0, and no RAM strobe asserted.
REQ-009 Write path: the FSM SHALL go IDLE -> WRITE -> DONE, with ram_we=1 for exactly the one WRITE cycle and ram_addr/ram_din driven from the latches; done follows 2 cycles after gnt.
REQ-010 Read path: the FSM SHALL go IDLE -> RD_REQ -> RD_WAIT, with ram_rd_req=1 for exactly the one RD_REQ cycle.
REQ-011 In RD_WAIT, on ram_rd_pres=1 the block SHALL capture ram_dout into the owner's rdata register, assert ram_rd_ack for that single cycle, and go to DONE.
REQ-012 The RD_WAIT timeout counter SHALL clear on entry and increment each cycle; at all-ones without ram_rd_pres, the FSM SHALL go to DONE with err pulsed, owner rdata=0, and no ram_rd_ack.
REQ-013 If ram_rd_pres and timeout coincide, ram_rd_pres SHALL win and no err is raised.
REQ-014 DONE SHALL last one cycle: pulse only the owner's done, update last-served to the owner, and return to IDLE, where a new gnt may issue in the very next cycle.
REQ-015 rdata of the non-owner SHALL hold its previous value.
REQ-016 ram_addr/ram_din SHALL hold the latched values outside IDLE; ram_we, ram_rd_req, and ram_rd_ack SHALL be 0 except as stated above.
REQ-017 The block SHALL not wait on ram_rdy outside IDLE; an in-flight transaction completes or times out.

Reset
REQ-018 On reset low, asynchronously: state=IDLE, all gnt/done/err/busy/ram strobes=0, ram_addr/ram_din/rdata/latches/counter=0, last-served=A (so B has priority).
REQ-019 Reset mid-transaction SHALL abandon it with no done pulse; operation resumes on the first clk edge after reset goes high.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- A write addr 0x10, data 0xBEEF, ram_rdy=1 -> a_gnt at cycle 0, ram_we high at cycle 1 with addr 0x10/din 0xBEEF, a_done at cycle 2.
- B read addr 0x20, ram_rd_pres 5 cycles after ram_rd_req with dout 0x1234 -> single ram_rd_ack; b_done with b_rdata=0x1234.
- a_req and b_req held high from reset for 4 transactions -> grant order B, A, B, A.
- A read with ram_max_addr=0xFF, a_addr=0x100 -> err and a_done pulse together, a_rdata=0, no ram_rd_req.
- Read with ram_rd_pres never asserted -> err and done at 1023 cycles in RD_WAIT, rdata=0, no ram_rd_ack.
- Reset asserted in RD_WAIT -> all outputs 0 immediately; no done; next request granted normally.

Source files
------------

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// ram_arbiter : round-robin arbiter placing two requesters onto one RAM wrapper
// Revision    : 1.0
// ============================================================================
module ram_arbiter #(
    parameter int ADDR_W = 26,
    parameter int DATA_W = 16,
    parameter int TMO_W  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_done,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_done,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    output logic              ram_rd_req,
    output logic              ram_rd_ack,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic              ram_rdy,
    input  logic              ram_rd_pres,
    input  logic [ADDR_W-1:0] ram_max_addr,
    output logic              busy,
    output logic              err
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic             c_own_a   = 1'b0;
    localparam logic             c_own_b   = 1'b1;
    localparam logic [TMO_W-1:0] c_tmo_one = TMO_W'(1);

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_q, last_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                err_q, err_d;

    logic                sel_b;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            owner_q   <= c_own_a;
            last_q    <= c_own_a;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        a_gnt      = 1'b0;
        b_gnt      = 1'b0;
        ram_rd_ack = 1'b0;

        // B wins a tie only when A was the last one served
        sel_b     = b_req && (!a_req || (last_q == c_own_a));
        sel_we    = sel_b ? b_we    : a_we;
        sel_addr  = sel_b ? b_addr  : a_addr;
        sel_wdata = sel_b ? b_wdata : a_wdata;

        case (state_q)
            IDLE: begin
                if (reset && ram_rdy && (a_req || b_req)) begin
                    a_gnt   = !sel_b;
                    b_gnt   = sel_b;
                    owner_d = sel_b;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    err_d   = 1'b0;
                    if (sel_addr > ram_max_addr) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                        if (sel_b) b_rdata_d = '0;
                        else       a_rdata_d = '0;
                    end else if (sel_we) begin
                        state_d = WRITE;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            WRITE: state_d = DONE;
            RD_REQ: begin
                tmo_d   = '0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                // data arriving on the last timeout cycle still counts
                if (ram_rd_pres) begin
                    ram_rd_ack = 1'b1;
                    if (owner_q == c_own_b) b_rdata_d = ram_dout;
                    else                    a_rdata_d = ram_dout;
                    state_d = DONE;
                end else if (&tmo_q) begin
                    err_d = 1'b1;
                    if (owner_q == c_own_b) b_rdata_d = '0;
                    else                    a_rdata_d = '0;
                    state_d = DONE;
                end else begin
                    tmo_d = tmo_q + c_tmo_one;
                end
            end
            DONE: begin
                last_d  = owner_q;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ram_addr   = addr_q;
    assign ram_din    = wdata_q;
    assign ram_we     = (state_q == WRITE);
    assign ram_rd_req = (state_q == RD_REQ);
    assign a_done     = (state_q == DONE) && (owner_q == c_own_a);
    assign b_done     = (state_q == DONE) && (owner_q == c_own_b);
    assign err        = (state_q == DONE) && err_q;
    assign busy       = (state_q != IDLE);
    assign a_rdata    = a_rdata_q;
    assign b_rdata    = b_rdata_q;

    // we_q is kept for the transaction record; the path choice is made at grant time
    logic unused_we;
    assign unused_we = we_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// tb_ram_arbiter : randomized scoreboard bench for ram_arbiter with a RAM responder
module tb_ram_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [25:0] a_addr = '0, b_addr = '0, ram_max_addr = 26'h3FFFFFF;
    logic [15:0] a_wdata = '0, b_wdata = '0, ram_dout = '0;
    logic        ram_rdy = 1'b1, ram_rd_pres = 1'b0;
    logic        a_gnt, a_done, b_gnt, b_done, ram_we, ram_rd_req, ram_rd_ack, busy, err;
    logic [15:0] a_rdata, b_rdata, ram_din;
    logic [25:0] ram_addr;

    ram_arbiter dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_rd_req(ram_rd_req), .ram_rd_ack(ram_rd_ack), .ram_dout(ram_dout),
        .ram_rdy(ram_rdy), .ram_rd_pres(ram_rd_pres), .ram_max_addr(ram_max_addr),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          who;
        bit          err;
        logic [15:0] rdata;
        logic [15:0] other;
        int          lat;
        int          n_we, n_rr, n_ack;
        logic [25:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    bit          cur_valid = 1'b0;
    int          checks = 0, errors = 0, cyc = 0;
    int          gnt_cyc = 0, cnt_we = 0, cnt_rr = 0, cnt_ack = 0;
    int          rd_lat = 3, cd = 0;
    logic [15:0] rd_value = '0;
    logic [15:0] ram_mem[int];
    logic [15:0] model_mem[int];
    logic [15:0] model_rdata[2];
    bit          model_last = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] init_val(input int a);
        return 16'(a * 40503 + 23130);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RAM wrapper model: stores writes, answers reads rd_lat cycles after the request
    always @(negedge clk) begin
        if (!reset) begin
            cd = 0;
        end else begin
            if (ram_we) ram_mem[int'(ram_addr)] = ram_din;
            if (cd > 0) cd--;
            if (ram_rd_req) begin
                cd = rd_lat;
                rd_value = ram_mem.exists(int'(ram_addr)) ? ram_mem[int'(ram_addr)]
                                                          : init_val(int'(ram_addr));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        ram_rd_pres = (cd == 1) && reset;
        ram_dout    = (cd == 1) ? rd_value : 16'h0;
    end

    // Monitor: pops the expected transaction at grant, scores strobes and completion
    always @(negedge clk) begin
        if (!reset) begin
            cur_valid = 1'b0;
        end else begin
            if (!cur_valid && (ram_we || ram_rd_req || ram_rd_ack))
                chk("stray_strobe", {61'd0, ram_we, ram_rd_req, ram_rd_ack}, 64'd0);
            if (a_gnt || b_gnt) begin
                chk("gnt_onehot", {63'd0, a_gnt & b_gnt}, 64'd0);
                chk("gnt_expected", {63'd0, (exp_q.size() != 0) && !cur_valid}, 64'd1);
                if (exp_q.size() != 0 && !cur_valid) begin
                    cur = exp_q.pop_front();
                    cur_valid = 1'b1;
                    chk("gnt_who", {63'd0, b_gnt}, {63'd0, cur.who});
                    gnt_cyc = cyc;
                    cnt_we = 0; cnt_rr = 0; cnt_ack = 0;
                end
            end
            if (cur_valid) begin
                if (ram_we) begin
                    cnt_we++;
                    chk("we_addr", 64'(ram_addr), 64'(cur.addr));
                    chk("we_din", 64'(ram_din), 64'(cur.data));
                end
                if (ram_rd_req) begin
                    cnt_rr++;
                    chk("rd_addr", 64'(ram_addr), 64'(cur.addr));
                end
                if (ram_rd_ack) cnt_ack++;
            end
            if (a_done || b_done) begin
                chk("done_expected", {63'd0, cur_valid}, 64'd1);
                if (cur_valid) begin
                    chk("done_who", {62'd0, a_done, b_done}, cur.who ? 64'd1 : 64'd2);
                    chk("done_err", {63'd0, err}, {63'd0, cur.err});
                    chk("rdata_owner", 64'(cur.who ? b_rdata : a_rdata), 64'(cur.rdata));
                    chk("rdata_other", 64'(cur.who ? a_rdata : b_rdata), 64'(cur.other));
                    chk("done_latency", 64'(cyc - gnt_cyc), 64'(cur.lat));
                    chk("n_ram_we", 64'(cnt_we), 64'(cur.n_we));
                    chk("n_ram_rd_req", 64'(cnt_rr), 64'(cur.n_rr));
                    chk("n_ram_rd_ack", 64'(cnt_ack), 64'(cur.n_ack));
                    cur_valid = 1'b0;
                end
            end else if (err) begin
                chk("err_without_done", {63'd0, err}, 64'd0);
            end
        end
    end

    // Reference model: outcome of one transaction from the arbitration/RAM rules
    task automatic model_txn(input bit who, input bit we, input logic [25:0] addr,
                             input logic [15:0] d, input logic [25:0] maxa, input int lat);
        exp_t e;
        int   a = int'(addr);
        e.who = who; e.addr = addr; e.data = d;
        e.n_we = 0; e.n_rr = 0; e.n_ack = 0;
        if (addr > maxa) begin
            e.err = 1'b1; e.rdata = 16'h0; e.lat = 1;
        end else if (we) begin
            e.err = 1'b0; e.rdata = model_rdata[who]; e.lat = 2; e.n_we = 1;
            model_mem[a] = d;
        end else begin
            e.n_rr = 1;
            if (lat >= 1 && lat <= 1024) begin
                e.err = 1'b0; e.n_ack = 1; e.lat = 2 + lat;
                e.rdata = model_mem.exists(a) ? model_mem[a] : init_val(a);
            end else begin
                e.err = 1'b1; e.rdata = 16'h0; e.lat = 1026;
            end
        end
        model_rdata[who] = e.rdata;
        e.other = model_rdata[!who];
        model_last = who;
        exp_q.push_back(e);
    endtask

    task automatic push(input bit who);
        model_txn(who, who ? b_we : a_we, who ? b_addr : a_addr,
                  who ? b_wdata : a_wdata, ram_max_addr, rd_lat);
    endtask

    task automatic drive(input bit ra, input bit rb, input int n_gnt, input bit hold);
        int seen = 0;
        int guard = 0;
        bit ga, gb;
        a_req = ra; b_req = rb;
        while (seen < n_gnt && guard < 5000) begin
            @(negedge clk);
            ga = a_gnt; gb = b_gnt;
            seen += int'(ga) + int'(gb);
            guard++;
            @(posedge clk); #1;
            if (!hold && ga) a_req = 1'b0;
            if (!hold && gb) b_req = 1'b0;
        end
        a_req = 1'b0; b_req = 1'b0;
        if (guard >= 5000) chk("grant_timeout", 64'(seen), 64'(n_gnt));
    endtask

    task automatic wait_done();
        int g = 0;
        while ((cur_valid || exp_q.size() != 0 || busy) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 3000) chk("done_timeout", 64'(exp_q.size() + int'(cur_valid)), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic txn(input bit ra, input bit rb);
        bit w;
        if (ra && rb) begin
            w = !model_last;
            push(w);
            push(!w);
        end else begin
            push(rb);
        end
        drive(ra, rb, int'(ra) + int'(rb), 1'b0);
        wait_done();
    endtask

    task automatic set_a(input bit we, input logic [25:0] ad, input logic [15:0] d);
        a_we = we; a_addr = ad; a_wdata = d;
    endtask

    task automatic set_b(input bit we, input logic [25:0] ad, input logic [15:0] d);
        b_we = we; b_addr = ad; b_wdata = d;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_strobes"}, {55'd0, a_gnt, b_gnt, a_done, b_done, err, busy,
                                ram_we, ram_rd_req, ram_rd_ack}, 64'd0);
        chk({tag, "_ram_addr"}, 64'(ram_addr), 64'd0);
        chk({tag, "_ram_din"}, 64'(ram_din), 64'd0);
        chk({tag, "_a_rdata"}, 64'(a_rdata), 64'd0);
        chk({tag, "_b_rdata"}, 64'(b_rdata), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        model_rdata[0] = '0;
        model_rdata[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;
        ram_max_addr = 26'h3F;

        // both requests held from reset: B, A, B, A
        set_a(1'b1, 26'h1, 16'hA001);
        set_b(1'b1, 26'h2, 16'hB002);
        for (int i = 0; i < 4; i++) push(!model_last);
        drive(1'b1, 1'b1, 4, 1'b1);
        wait_done();

        // A write 0x10 / 0xBEEF
        set_a(1'b1, 26'h10, 16'hBEEF);
        txn(1'b1, 1'b0);

        // B read 0x20, data arrives 5 cycles after the request
        ram_mem[32'h20] = 16'h1234;
        model_mem[32'h20] = 16'h1234;
        rd_lat = 5;
        set_b(1'b0, 26'h20, 16'h0);
        txn(1'b0, 1'b1);

        // out-of-range read
        ram_max_addr = 26'hFF;
        set_a(1'b0, 26'h100, 16'h0);
        txn(1'b1, 1'b0);
        ram_max_addr = 26'h3F;

        // RAM not ready: request must be ignored
        ram_rdy = 1'b0;
        set_a(1'b1, 26'h3, 16'h3333);
        a_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rdy_low_no_gnt", {62'd0, a_gnt, busy}, 64'd0);
        end
        @(posedge clk); #1;
        a_req = 1'b0;
        ram_rdy = 1'b1;

        // read timeout, then data exactly on the last timeout cycle
        rd_lat = 0;
        set_a(1'b0, 26'h10, 16'h0);
        txn(1'b1, 1'b0);
        rd_lat = 1024;
        set_b(1'b0, 26'h10, 16'h0);
        txn(1'b0, 1'b1);

        // reset while waiting for read data
        rd_lat = 0;
        set_b(1'b0, 26'h22, 16'h0);
        push(1'b1);
        drive(1'b0, 1'b1, 1, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        set_a(1'b1, 26'h5, 16'h55AA);
        a_req = 1'b1;
        reset = 1'b0;
        #1;
        check_all_zero("mid_reset");
        exp_q.delete();
        model_last = 1'b0;
        model_rdata[0] = '0;
        model_rdata[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        a_req = 1'b0;
        reset = 1'b1;
        txn(1'b1, 1'b0);

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            int mode;
            mode = int'($urandom_range(0, 2));
            set_a(1'($urandom_range(0, 1)), 26'($urandom_range(0, 79)), 16'($urandom));
            set_b(1'($urandom_range(0, 1)), 26'($urandom_range(0, 79)), 16'($urandom));
            rd_lat = int'($urandom_range(1, 8));
            txn(mode != 1, mode != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
